// File: rtl/dma_dsc_cache_ctrl.sv
// Descriptor cache controller: FIFO of descriptors stored in a 4x88 two-stage registered
// micro-RAM, with write port from the fetch engine and read port toward the channel engine.
module dma_dsc_cache_ctrl #(
   parameter int unsigned DATA_W = 88,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              FLUSH,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [DATA_W-1:0] WR_DATA,
   output logic              RD_VALID,
   input  logic              RD_READY,
   output logic [DATA_W-1:0] RD_DATA,
   output logic [ADDR_W:0]   COUNT,
   output logic              SRAM_BLK_EN,
   output logic              SRAM_W_EN,
   output logic [ADDR_W-1:0] SRAM_W_ADDR,
   output logic [DATA_W-1:0] SRAM_W_DATA,
   output logic [ADDR_W-1:0] SRAM_R_ADDR,
   output logic              SRAM_R_ADDR_EN,
   output logic              SRAM_R_DATA_EN,
   output logic              SRAM_SRST_N,
   input  logic [DATA_W-1:0] SRAM_R_DATA
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_VALID} t_rd_state;

   localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LP_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LP_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   t_rd_state         r_state;
   t_rd_state         w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   w_unfetched;
   logic              w_run;
   logic              w_wr_hs;
   logic              w_rd_hs;
   logic              w_addr_en;
   logic              w_data_en;

   assign w_run    = RESETN & ~FLUSH;
   assign WR_READY = w_run & (r_count < LP_DEPTH);
   assign w_wr_hs  = WR_VALID & WR_READY;
   assign RD_VALID = (r_state == ST_VALID);
   assign w_rd_hs  = RD_VALID & RD_READY;

   // Entries not yet launched into the RAM read pipeline; uses registered COUNT so a
   // read never chases the slot being written this cycle.
   assign w_unfetched = r_count - {{ADDR_W{1'b0}}, (r_state != ST_IDLE)};

   always_comb begin
      w_state_nxt = r_state;
      w_addr_en   = 1'b0;
      w_data_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_unfetched != '0) begin
               w_addr_en   = 1'b1;
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            w_data_en   = 1'b1;
            w_state_nxt = ST_VALID;
         end
         ST_VALID: begin
            if (RD_READY) begin
               if (w_unfetched != '0) begin
                  w_addr_en   = 1'b1;
                  w_state_nxt = ST_ADDR;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETN || FLUSH) begin
         r_state  <= ST_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_hs) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         if (w_rd_hs) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         case ({w_wr_hs, w_rd_hs})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // In VALID the next launch targets the slot after the head being consumed.
   assign SRAM_R_ADDR    = (r_state == ST_VALID) ? (r_rd_ptr + LP_PTR_ONE) : r_rd_ptr;
   assign SRAM_R_ADDR_EN = w_run & w_addr_en;
   assign SRAM_R_DATA_EN = w_run & w_data_en;
   assign SRAM_SRST_N    = w_run;
   assign SRAM_BLK_EN    = 1'b1;
   assign SRAM_W_EN      = w_wr_hs;
   assign SRAM_W_ADDR    = r_wr_ptr;
   assign SRAM_W_DATA    = WR_DATA;
   assign RD_DATA        = SRAM_R_DATA;
   assign COUNT          = r_count;

endmodule

// File: tb/tb_dma_dsc_cache_ctrl.sv
// Bench for dma_dsc_cache_ctrl with a behavioural two-stage registered RAM and an
// in-order scoreboard checked by a monitor on every read handshake.
module tb_dma_dsc_cache_ctrl;

   logic        CLK = 1'b0;
   logic        RESETN, FLUSH, WR_VALID, RD_READY;
   logic [87:0] WR_DATA;
   logic        WR_READY, RD_VALID;
   logic [87:0] RD_DATA;
   logic [2:0]  COUNT;
   logic        SRAM_BLK_EN, SRAM_W_EN, SRAM_R_ADDR_EN, SRAM_R_DATA_EN, SRAM_SRST_N;
   logic [1:0]  SRAM_W_ADDR, SRAM_R_ADDR;
   logic [87:0] SRAM_W_DATA, SRAM_R_DATA;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_popped = 0;
   logic        chk_cnt_bound = 1'b0;
   logic [87:0] q[$];

   always #5 CLK = ~CLK;

   dma_dsc_cache_ctrl #(.DATA_W(88), .DEPTH(4), .ADDR_W(2)) dut (
      .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
      .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
      .COUNT(COUNT), .SRAM_BLK_EN(SRAM_BLK_EN),
      .SRAM_W_EN(SRAM_W_EN), .SRAM_W_ADDR(SRAM_W_ADDR), .SRAM_W_DATA(SRAM_W_DATA),
      .SRAM_R_ADDR(SRAM_R_ADDR), .SRAM_R_ADDR_EN(SRAM_R_ADDR_EN),
      .SRAM_R_DATA_EN(SRAM_R_DATA_EN), .SRAM_SRST_N(SRAM_SRST_N),
      .SRAM_R_DATA(SRAM_R_DATA)
   );

   // Micro-RAM model: registered read address, then registered read data.
   logic [87:0] mem [4];
   logic [1:0]  ram_ra;
   always @(posedge CLK) begin
      if (SRAM_W_EN) mem[SRAM_W_ADDR] <= SRAM_W_DATA;
      if (!SRAM_SRST_N) begin
         ram_ra      <= '0;
         SRAM_R_DATA <= '0;
      end else begin
         if (SRAM_R_ADDR_EN) ram_ra <= SRAM_R_ADDR;
         if (SRAM_R_DATA_EN) SRAM_R_DATA <= mem[ram_ra];
      end
   end

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [87:0] act, input logic [87:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: in-order data check on each read handshake, plus the hold rule.
   logic        held = 1'b0;
   logic [87:0] held_data;
   always @(negedge CLK) begin
      if (RESETN && !FLUSH) begin
         if (chk_cnt_bound) chk("count_le_depth", 32'(COUNT <= 3'd4), 1);
         if (RD_VALID) begin
            if (held) chkd("rd_data_hold", RD_DATA, held_data);
            if (RD_READY) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_read: got %h expected none", RD_DATA);
               end else begin
                  chkd("rd_data_order", RD_DATA, q.pop_front());
               end
               n_popped++;
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_data = RD_DATA;
            end
         end else begin
            held = 1'b0;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Offer one descriptor until accepted (bounded); expectation queued on acceptance.
   task automatic wr(input logic [87:0] d);
      logic ok;
      ok       = 1'b0;
      WR_VALID = 1'b1;
      WR_DATA  = d;
      for (int unsigned i = 0; i < 64 && !ok; i++) begin
         @(negedge CLK);
         if (WR_READY) begin
            q.push_back(d);
            ok = 1'b1;
         end
         cyc();
      end
      WR_VALID = 1'b0;
      if (!ok) chk("wr_timeout", 0, 1);
   endtask

   // Single-cycle write that must be accepted at a known RAM address.
   task automatic wr_chk(input logic [87:0] d, input int unsigned addr);
      WR_VALID = 1'b1;
      WR_DATA  = d;
      @(negedge CLK);
      chk("wr_ready", 32'(WR_READY), 1);
      chk("sram_w_en", 32'(SRAM_W_EN), 1);
      chk("sram_w_addr", 32'(SRAM_W_ADDR), addr);
      chkd("sram_w_data", SRAM_W_DATA, d);
      q.push_back(d);
      cyc();
      WR_VALID = 1'b0;
   endtask

   task automatic writer4();
      for (int unsigned i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 2)) cyc();
         wr({8'hD4, 72'h0, 8'(i)});
      end
   endtask

   task automatic reader4();
      for (int unsigned c = 0; c < 600 && n_popped < 10; c++) begin
         RD_READY = 1'($urandom_range(0, 1));
         cyc();
      end
      RD_READY = 1'b0;
      chk("t4_all_drained", n_popped, 10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESETN = 1'b0; FLUSH = 1'b0; WR_VALID = 1'b0; RD_READY = 1'b0; WR_DATA = '0;
      repeat (3) cyc();
      @(negedge CLK);
      chk("rst_wr_ready", 32'(WR_READY), 0);
      chk("rst_rd_valid", 32'(RD_VALID), 0);
      chk("rst_count", 32'(COUNT), 0);
      chk("rst_w_en", 32'(SRAM_W_EN), 0);
      chk("rst_r_addr_en", 32'(SRAM_R_ADDR_EN), 0);
      chk("rst_r_data_en", 32'(SRAM_R_DATA_EN), 0);
      chk("rst_srst_n", 32'(SRAM_SRST_N), 0);
      chk("rst_blk_en", 32'(SRAM_BLK_EN), 1);
      cyc();
      RESETN = 1'b1;

      // 1: single descriptor latency
      cyc();
      wr(88'hA5);
      @(negedge CLK);
      chk("t1_c1_rd_valid", 32'(RD_VALID), 0);
      chk("t1_c1_count", 32'(COUNT), 1);
      chk("t1_c1_r_addr_en", 32'(SRAM_R_ADDR_EN), 1);
      chk("t1_c1_r_addr", 32'(SRAM_R_ADDR), 0);
      cyc();
      @(negedge CLK);
      chk("t1_c2_rd_valid", 32'(RD_VALID), 0);
      chk("t1_c2_r_data_en", 32'(SRAM_R_DATA_EN), 1);
      cyc();
      RD_READY = 1'b1;
      @(negedge CLK);
      chk("t1_c3_rd_valid", 32'(RD_VALID), 1);
      chk("t1_c3_count", 32'(COUNT), 1);
      cyc();
      RD_READY = 1'b0;
      @(negedge CLK);
      chk("t1_after_count", 32'(COUNT), 0);
      chk("t1_after_rd_valid", 32'(RD_VALID), 0);

      // 2: fill to full, fifth write refused
      cyc();
      wr_chk(88'h1111, 1);
      wr(88'h2222_2222);
      wr(88'h3333_0000_3333);
      wr(88'hFF00FF00FF00FF00FF00FF);
      WR_VALID = 1'b1;
      WR_DATA  = 88'hBAD;
      for (int unsigned j = 0; j < 2; j++) begin
         @(negedge CLK);
         chk("t2_full_count", 32'(COUNT), 4);
         chk("t2_full_wr_ready", 32'(WR_READY), 0);
         chk("t2_full_w_en", 32'(SRAM_W_EN), 0);
         chk("t2_full_rd_valid", 32'(RD_VALID), 1);
         cyc();
      end
      WR_VALID = 1'b0;

      // 3: drain full cache at one descriptor per two cycles
      RD_READY = 1'b1;
      for (int unsigned j = 0; j < 8; j++) begin
         @(negedge CLK);
         chk("t3_drain_rd_valid", 32'(RD_VALID), 32'((j % 2) == 0));
         cyc();
      end
      RD_READY = 1'b0;
      @(negedge CLK);
      chk("t3_count_empty", 32'(COUNT), 0);
      chk("t3_rd_valid_empty", 32'(RD_VALID), 0);

      // 4: random interleaved traffic across pointer wrap
      n_popped      = 0;
      chk_cnt_bound = 1'b1;
      cyc();
      fork
         writer4();
         reader4();
      join
      chk_cnt_bound = 1'b0;
      @(negedge CLK);
      chk("t4_count_end", 32'(COUNT), 0);

      // 5: flush with two held, then a fresh write from address 0
      cyc();
      wr(88'hE1);
      wr(88'hE2);
      cyc();
      @(negedge CLK);
      chk("t5_pre_rd_valid", 32'(RD_VALID), 1);
      chk("t5_pre_count", 32'(COUNT), 2);
      cyc();
      FLUSH = 1'b1;
      q.delete();
      @(negedge CLK);
      chk("t5_flush_wr_ready", 32'(WR_READY), 0);
      chk("t5_flush_srst_n", 32'(SRAM_SRST_N), 0);
      cyc();
      FLUSH = 1'b0;
      @(negedge CLK);
      chk("t5_post_count", 32'(COUNT), 0);
      chk("t5_post_rd_valid", 32'(RD_VALID), 0);
      cyc();
      wr_chk(88'hE3, 0);
      cyc();
      cyc();
      RD_READY = 1'b1;
      @(negedge CLK);
      chk("t5_new_rd_valid", 32'(RD_VALID), 1);
      cyc();
      RD_READY = 1'b0;
      @(negedge CLK);
      chk("t5_new_count", 32'(COUNT), 0);

      // 6: full with read handshake, then simultaneous read and write
      cyc();
      wr(88'hF0);
      wr(88'hF1);
      wr(88'hF2);
      wr(88'hF3);
      RD_READY = 1'b1;
      WR_VALID = 1'b1;
      WR_DATA  = 88'hF4;
      @(negedge CLK);
      chk("t6_full_count", 32'(COUNT), 4);
      chk("t6_full_wr_ready", 32'(WR_READY), 0);
      chk("t6_full_rd_valid", 32'(RD_VALID), 1);
      cyc();
      RD_READY = 1'b0;
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("t6_after_count", 32'(COUNT), 3);
      chk("t6_after_wr_ready", 32'(WR_READY), 1);
      cyc();
      RD_READY = 1'b1;
      WR_VALID = 1'b1;
      @(negedge CLK);
      chk("t6_both_rd_valid", 32'(RD_VALID), 1);
      chk("t6_both_wr_ready", 32'(WR_READY), 1);
      q.push_back(88'hF4);
      cyc();
      RD_READY = 1'b0;
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("t6_both_count", 32'(COUNT), 3);
      cyc();
      RD_READY = 1'b1;
      repeat (10) cyc();
      RD_READY = 1'b0;
      @(negedge CLK);
      chk("t6_final_count", 32'(COUNT), 0);
      chk("t6_final_rd_valid", 32'(RD_VALID), 0);
      chk("t6_scoreboard_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
